serial_output_tx: RTL and testbench
===================================

Name: serial_output_tx

Overview:
- Transmit-side counterpart of the shift accumulator.
- Takes finished 40-bit left/right filter results and serializes them MSB-first onto the MSDAP serial outputs, one bit per Sclk.
- Holds one frame in flight plus a single pending frame, so the accumulator can hand off its next result while the current one is still shifting out.
- Sits between the left/right shift accumulators and the chip-level OutputL/OutputR/OutReady pins.

Parameters:
- WIDTH, 40, bits per output word; the frame length in Sclk cycles.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Sclk  input  1  system serial clock; all state changes on the rising edge.
- clear  input  1  reset, asynchronous, active-high; forces all state and outputs to reset values immediately.
- load  input  1  request to transmit data_l/data_r; sampled on the Sclk rising edge.
- data_l  input  WIDTH  left-channel word, two's complement.
- data_r  input  WIDTH  right-channel word, two's complement.
- ready  output  1  high when a load on this edge will be accepted (pending slot empty).
- OutputL  output  1  serial left data, MSB first.
- OutputR  output  1  serial right data, MSB first.
- OutReady  output  1  high for every cycle a valid bit is on OutputL/OutputR.
- frame_done  output  1  one-cycle pulse after the last bit of a frame has been presented.
- overflow  output  1  sticky; set when a load is dropped.

Behaviour:
- State: sreg_l/sreg_r (WIDTH), pend_l/pend_r (WIDTH), pend_valid, bit_cnt (CNT_W), FSM {IDLE, SHIFT}.
- Reset (clear=1, async): FSM=IDLE; all registers 0; OutputL=OutputR=0; OutReady=0; frame_done=0; overflow=0; ready=1.
- ready = !pend_valid, combinational. overflow is cleared only by clear.
- OutputL=sreg_l[WIDTH-1], OutputR=sreg_r[WIDTH-1]. Both are forced to 0 when OutReady=0.
- IDLE, load=1 at edge k:
  - sreg<=data, bit_cnt<=0, FSM->SHIFT.
  - Bit 39 is visible after edge k; OutReady=1 after edge k.
  - Zero-cycle latency from the load edge to the first bit.
- SHIFT:
  - Each edge: sreg<=sreg<<1 (zero fill), bit_cnt++.
  - Bit i (39..0) is presented during cycle k+(39-i).
  - Exactly WIDTH cycles of OutReady per frame.
- End of frame (edge with bit_cnt==WIDTH-1, i.e. edge k+40): frame_done=1 for the following cycle. Then:
  - pend_valid=1: sreg<=pend, pend_valid<=0, bit_cnt<=0, stay SHIFT. OutReady stays high with no gap cycle.
  - pend_valid=0 and load=1: sreg<=data directly, stay SHIFT, back-to-back.
  - pend_valid=0 and load=0: FSM->IDLE, OutReady=0, sreg<=0.
- load during SHIFT, not at the end-of-frame edge:
  - pend_valid=0: pend<=data, pend_valid<=1.
  - pend_valid=1: word dropped, overflow<=1, pend unchanged.
- load at the end-of-frame edge with pend_valid=1: pend moves to sreg and the new data goes into pend (pend_valid stays 1). No overflow.
- load while clear=1: ignored.
- clear mid-frame:
  - Outputs go to 0 immediately and the frame is abandoned; no frame_done.
  - After release, the first load edge starts a fresh frame.
- Data is transmitted bit-exact. No sign extension, rounding or saturation.
- Left and right are always loaded and shifted together. The two outputs are bit-aligned every cycle.

Test Plan:
- Reset then idle 10 cycles -> OutReady=0, OutputL=OutputR=0, ready=1, overflow=0, frame_done=0.
- Single load, data_l=40'h80_0000_0001, data_r=40'h7F_FFFF_FFFE:
  - OutReady high for exactly 40 cycles.
  - OutputL stream is 1, 38×0, 1; OutputR stream is 0, 38×1, 0.
  - frame_done pulses once, then IDLE.
- Load A, load B at cycle 5 (accepted, ready drops), load C at cycle 10:
  - C dropped, overflow=1.
  - A then B transmitted with no gap: 80 contiguous OutReady cycles, two frame_done pulses.
- Load exactly at the end-of-frame edge with the pending slot empty -> next frame starts with no gap, and overflow stays 0.
- Load exactly at the end-of-frame edge with the pending slot full:
  - Pending word is transmitted next and the new word becomes pending.
  - Three frames sent in total, overflow stays 0.
- clear asserted at bit 20 of a frame, mid-cycle:
  - Outputs zero immediately; overflow cleared; no frame_done.
  - A later load of 40'hFF_FFFF_FFFF/0 transmits correctly.

Source files
------------

// File: rtl/serial_output_tx.sv
// serial_output_tx
//   Serializes finished 40-bit left/right filter results MSB-first onto the
//   MSDAP serial outputs, one bit per Sclk. One word is in flight in the shift
//   registers and one more may wait in the pending slot. This lets the shift
//   accumulators hand off their next result while the current one shifts out.
//
// Handshake: a word is accepted on a rising Sclk edge where load=1 and either
//   the FSM is idle, the pending slot is empty (ready=1), or the edge is the
//   end-of-frame edge, where the pending word moves into the shifter and
//   frees the slot. A load on any other edge with the slot full is dropped
//   and sets the sticky overflow flag.
//
// Ports:
//   Sclk        serial clock, all state changes on its rising edge
//   clear       asynchronous active-high reset
//   load        transmit request for data_l/data_r
//   data_l/r    WIDTH-bit two's complement words, sent bit-exact
//   ready       pending slot empty
//   OutputL/R   serial data, MSB first, forced to 0 when OutReady=0
//   OutReady    high for every cycle a valid bit is presented
//   frame_done  one-cycle pulse after the last bit of a frame
//   overflow    sticky, set when a load is dropped, cleared only by clear

module serial_output_tx #(
   parameter int WIDTH = 40,
   parameter int CNT_W = 6   // 2**CNT_W must exceed WIDTH
) (
   input  logic             Sclk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] data_l,
   input  logic [WIDTH-1:0] data_r,
   output logic             ready,
   output logic             OutputL,
   output logic             OutputR,
   output logic             OutReady,
   output logic             frame_done,
   output logic             overflow
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg_l, sreg_l_nx, sreg_r, sreg_r_nx;
   logic [WIDTH-1:0] pend_l, pend_l_nx, pend_r, pend_r_nx;
   logic             pend_valid, pend_valid_nx;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
   logic             frame_done_nx, overflow_nx;
   logic             end_of_frame;

   // The edge that retires bit 0 of the current word.
   assign end_of_frame = (state == SHIFT) && (bit_cnt == LAST_BIT);

   always_ff @(posedge Sclk or posedge clear) begin
      if (clear) begin
         state      <= IDLE;
         sreg_l     <= '0;
         sreg_r     <= '0;
         pend_l     <= '0;
         pend_r     <= '0;
         pend_valid <= 1'b0;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nx;
         sreg_l     <= sreg_l_nx;
         sreg_r     <= sreg_r_nx;
         pend_l     <= pend_l_nx;
         pend_r     <= pend_r_nx;
         pend_valid <= pend_valid_nx;
         bit_cnt    <= bit_cnt_nx;
         frame_done <= frame_done_nx;
         overflow   <= overflow_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      sreg_l_nx     = sreg_l;
      sreg_r_nx     = sreg_r;
      pend_l_nx     = pend_l;
      pend_r_nx     = pend_r;
      pend_valid_nx = pend_valid;
      bit_cnt_nx    = bit_cnt;
      frame_done_nx = 1'b0;
      overflow_nx   = overflow;

      case (state)
         IDLE: begin
            // The pending slot is always empty here, so a load goes straight
            // into the shifter and bit WIDTH-1 is on the pins next cycle.
            if (load) begin
               sreg_l_nx  = data_l;
               sreg_r_nx  = data_r;
               bit_cnt_nx = '0;
               state_nx   = SHIFT;
            end
         end
         SHIFT: begin
            if (end_of_frame) begin
               frame_done_nx = 1'b1;
               bit_cnt_nx    = '0;
               if (pend_valid) begin
                  // Pending word starts with no gap. A simultaneous load
                  // refills the slot that is being vacated on this edge.
                  sreg_l_nx = pend_l;
                  sreg_r_nx = pend_r;
                  if (load) begin
                     pend_l_nx = data_l;
                     pend_r_nx = data_r;
                  end else begin
                     pend_valid_nx = 1'b0;
                  end
               end else if (load) begin
                  sreg_l_nx = data_l;
                  sreg_r_nx = data_r;
               end else begin
                  sreg_l_nx = '0;
                  sreg_r_nx = '0;
                  state_nx  = IDLE;
               end
            end else begin
               sreg_l_nx  = {sreg_l[WIDTH-2:0], 1'b0};
               sreg_r_nx  = {sreg_r[WIDTH-2:0], 1'b0};
               bit_cnt_nx = bit_cnt + CNT_W'(1);
               if (load) begin
                  if (!pend_valid) begin
                     pend_l_nx     = data_l;
                     pend_r_nx     = data_r;
                     pend_valid_nx = 1'b1;
                  end else begin
                     overflow_nx = 1'b1;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign ready    = !pend_valid;
   assign OutReady = (state == SHIFT);
   assign OutputL  = OutReady & sreg_l[WIDTH-1];
   assign OutputR  = OutReady & sreg_r[WIDTH-1];

endmodule

// File: tb/tb_serial_output_tx.sv
// Self-checking bench for serial_output_tx: table-driven single frames plus
// hand-written sequences for pending/overflow/end-of-frame/clear corners.
// A negedge monitor rebuilds each serial word and checks it against the
// expected queue filled by the driver.

module tb_serial_output_tx;

   localparam int W = 40;

   logic         Sclk = 1'b0;
   logic         clear;
   logic         load;
   logic [W-1:0] data_l, data_r;
   logic         ready, OutputL, OutputR, OutReady, frame_done, overflow;

   serial_output_tx #(.WIDTH(W), .CNT_W(6)) dut (
      .Sclk       (Sclk),
      .clear      (clear),
      .load       (load),
      .data_l     (data_l),
      .data_r     (data_r),
      .ready      (ready),
      .OutputL    (OutputL),
      .OutputR    (OutputR),
      .OutReady   (OutReady),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   // ---------------- clock ----------------
   always #5 Sclk = ~Sclk;

   // ---------------- scoreboard / counters ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [2*W-1:0] exp_q[$];

   task automatic check(input string name, input logic [2*W-1:0] act,
                        input logic [2*W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // ---------------- monitor ----------------
   logic [W-1:0] sh_l = '0, sh_r = '0;
   int   nb = 0, run_len = 0, last_run = 0;
   int   fd_count = 0, fd_bad = 0, idle_bad = 0;
   logic fd_exp = 1'b0;

   always @(negedge Sclk) begin
      if (clear) begin
         nb      = 0;
         run_len = 0;
         fd_exp  = 1'b0;
         if (OutputL !== 1'b0 || OutputR !== 1'b0 || OutReady !== 1'b0 ||
             frame_done !== 1'b0) idle_bad++;
      end else begin
         if (frame_done !== fd_exp) fd_bad++;
         if (frame_done === 1'b1) fd_count++;
         fd_exp = 1'b0;
         if (OutReady === 1'b1) begin
            sh_l = {sh_l[W-2:0], OutputL};
            sh_r = {sh_r[W-2:0], OutputR};
            nb++;
            run_len++;
            if (nb == W) begin
               nb     = 0;
               fd_exp = 1'b1;
               check("sb_queue_nonempty", 2*W'(exp_q.size() != 0), 2*W'(1));
               if (exp_q.size() != 0) check("sb_word", {sh_l, sh_r}, exp_q.pop_front());
            end
         end else begin
            if (OutputL !== 1'b0 || OutputR !== 1'b0) idle_bad++;
            if (run_len != 0) last_run = run_len;
            run_len = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Sclk);
      #1;
   endtask

   task automatic do_reset();
      clear  = 1'b1;
      load   = 1'b0;
      data_l = '0;
      data_r = '0;
      repeat (3) tick();
      exp_q.delete();
      clear = 1'b0;
      tick();
   endtask

   task automatic load_word(input logic [W-1:0] l, input logic [W-1:0] r, input bit push);
      data_l = l;
      data_r = r;
      load   = 1'b1;
      if (push) exp_q.push_back({l, r});
      tick();
      load   = 1'b0;
      data_l = '0;
      data_r = '0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (OutReady === 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(name, 2*W'(OutReady === 1'b0), 2*W'(1));
      tick();
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [W-1:0] dl;
      logic [W-1:0] dr;
      logic         msb_l;
      logic         msb_r;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int           fd0;
      logic [W-1:0] t_l, t_r, d_l;

      clear  = 1'b1;
      load   = 1'b0;
      data_l = '0;
      data_r = '0;

      vecs[0] = '{40'h80_0000_0001, 40'h7F_FFFF_FFFE, 1'b1, 1'b0};
      vecs[1] = '{40'h00_0000_0000, 40'hFF_FFFF_FFFF, 1'b0, 1'b1};
      vecs[2] = '{40'hA5_5A5A_A55A, 40'h12_3456_789A, 1'b1, 1'b0};
      for (int i = 3; i < 5; i++) begin
         t_l = {8'($urandom_range(255)), 32'($urandom())};
         t_r = {8'($urandom_range(255)), 32'($urandom())};
         vecs[i] = '{t_l, t_r, t_l[W-1], t_r[W-1]};
      end

      // Reset then idle
      do_reset();
      repeat (10) tick();
      check("rst_outready",   2*W'(OutReady),   '0);
      check("rst_outputl",    2*W'(OutputL),    '0);
      check("rst_outputr",    2*W'(OutputR),    '0);
      check("rst_ready",      2*W'(ready),      2*W'(1));
      check("rst_overflow",   2*W'(overflow),   '0);
      check("rst_frame_done", 2*W'(frame_done), '0);

      // Table-driven single frames
      for (int i = 0; i < 5; i++) begin
         fd0 = fd_count;
         check("vec_ready", 2*W'(ready), 2*W'(1));
         load_word(vecs[i].dl, vecs[i].dr, 1'b1);
         check("vec_first_outready", 2*W'(OutReady), 2*W'(1));
         check("vec_first_bit_l", 2*W'(OutputL), 2*W'(vecs[i].msb_l));
         check("vec_first_bit_r", 2*W'(OutputR), 2*W'(vecs[i].msb_r));
         wait_idle("vec_idle_timeout", 60);
         check("vec_run_len", 2*W'(last_run), 2*W'(40));
         check("vec_frame_done", 2*W'(fd_count - fd0), 2*W'(1));
         check("vec_overflow", 2*W'(overflow), '0);
         repeat (2) tick();
      end

      // A, B pending at cycle 5, C dropped at cycle 10
      fd0 = fd_count;
      load_word(40'h11_2233_4455, 40'h66_7788_99AA, 1'b1);
      repeat (4) tick();
      check("abc_ready_before_b", 2*W'(ready), 2*W'(1));
      load_word(40'hF0_0F0F_F00F, 40'h0F_F0F0_0FF0, 1'b1);
      check("abc_ready_after_b", 2*W'(ready), '0);
      repeat (4) tick();
      load_word(40'hDE_ADBE_EF00, 40'h00_FEED_FACE, 1'b0);
      check("abc_overflow_set", 2*W'(overflow), 2*W'(1));
      wait_idle("abc_idle_timeout", 200);
      check("abc_run_len", 2*W'(last_run), 2*W'(80));
      check("abc_frame_done", 2*W'(fd_count - fd0), 2*W'(2));
      check("abc_overflow_sticky", 2*W'(overflow), 2*W'(1));

      // Clear mid-cycle at bit 20 (overflow is still set from above)
      fd0 = fd_count;
      d_l = 40'hC3_C3C3_C3C3;
      load_word(d_l, 40'h3C_3C3C_3C3C, 1'b1);
      repeat (19) tick();
      check("clr_bit20_l", 2*W'(OutputL), 2*W'(d_l[20]));
      #2 clear = 1'b1;
      #1;
      exp_q.delete();
      check("clr_outready", 2*W'(OutReady), '0);
      check("clr_outputl",  2*W'(OutputL),  '0);
      check("clr_outputr",  2*W'(OutputR),  '0);
      check("clr_overflow", 2*W'(overflow), '0);
      check("clr_ready",    2*W'(ready),    2*W'(1));
      repeat (2) tick();
      clear = 1'b0;
      repeat (45) tick();
      check("clr_no_frame_done", 2*W'(fd_count - fd0), '0);
      check("clr_stays_idle", 2*W'(OutReady), '0);
      fd0 = fd_count;
      load_word(40'hFF_FFFF_FFFF, 40'h00_0000_0000, 1'b1);
      check("clr_new_first_l", 2*W'(OutputL), 2*W'(1));
      wait_idle("clr_idle_timeout", 60);
      check("clr_new_run_len", 2*W'(last_run), 2*W'(40));
      check("clr_new_frame_done", 2*W'(fd_count - fd0), 2*W'(1));

      // Load exactly on end-of-frame edge, pending empty
      do_reset();
      fd0 = fd_count;
      load_word(40'h01_2345_6789, 40'hFE_DCBA_9876, 1'b1);
      repeat (39) tick();
      check("eof_ready", 2*W'(ready), 2*W'(1));
      load_word(40'h55_AA55_AA55, 40'hAA_55AA_55AA, 1'b1);
      check("eof_no_gap", 2*W'(OutReady), 2*W'(1));
      wait_idle("eof_idle_timeout", 200);
      check("eof_run_len", 2*W'(last_run), 2*W'(80));
      check("eof_frame_done", 2*W'(fd_count - fd0), 2*W'(2));
      check("eof_overflow", 2*W'(overflow), '0);

      // Load on end-of-frame edge with pending full
      do_reset();
      fd0 = fd_count;
      load_word(40'h10_0000_0001, 40'h20_0000_0002, 1'b1);
      repeat (4) tick();
      load_word(40'h30_0000_0003, 40'h40_0000_0004, 1'b1);
      repeat (34) tick();
      check("eofp_ready_full", 2*W'(ready), '0);
      load_word(40'h50_0000_0005, 40'h60_0000_0006, 1'b1);
      check("eofp_ready_after", 2*W'(ready), '0);
      check("eofp_overflow_now", 2*W'(overflow), '0);
      wait_idle("eofp_idle_timeout", 300);
      check("eofp_run_len", 2*W'(last_run), 2*W'(120));
      check("eofp_frame_done", 2*W'(fd_count - fd0), 2*W'(3));
      check("eofp_overflow", 2*W'(overflow), '0);
      check("eofp_ready_end", 2*W'(ready), 2*W'(1));

      // Final report
      repeat (3) tick();
      check("sb_drained", 2*W'(exp_q.size()), '0);
      check("frame_done_timing", 2*W'(fd_bad), '0);
      check("idle_outputs_zero", 2*W'(idle_bad), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
